// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkg
//  Description : Shared PPU constants and the serializer state encoding.
//                Holds the default visible raster size, the backdrop palette
//                index, and the group FIFO entry width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

   localparam int PPU_H_PIXELS = 256;
   localparam int PPU_V_LINES  = 240;

   localparam logic [7:0] BACKDROP_IDX = 8'h00;

   // One group = eight 8-bit palette indices plus the sprite-0 hit qualifier
   localparam int GROUP_PIX_W = 64;
   localparam int GROUP_W     = GROUP_PIX_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } ser_state_e;

endpackage : ppu_pkg
`default_nettype wire

// File: rtl/pixel_group_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_group_fifo
//  Description : Synchronous FIFO for pixel groups with synchronous flush.
//                Read data is the current head (show-ahead).
//  Ports       : clk, rst_n       - clock, async active-low reset
//                flush_i          - empty the FIFO this cycle (wins over push/pop)
//                push_i/wr_data_i - write one entry (ignored when full)
//                pop_i            - discard head (ignored when empty)
//                rd_data_o        - head entry
//                count_o, full_o, empty_o - occupancy status (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_group_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;

   logic w_push;
   logic w_pop;

   assign full_o    = (count_q == C_DEPTH);
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   assign w_push = push_i && !full_o  && !flush_i;
   assign w_pop  = pop_i  && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two
         if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (w_push && !w_pop)      count_d = count_q + 1'b1;
         else if (w_pop && !w_push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule : pixel_group_fifo
`default_nettype wire

// File: rtl/pixel_line_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_line_serializer
//  Description : Buffers 8-pixel groups and serializes them one pixel per
//                dot-enable into the visible raster, tracking X/Y, emitting
//                line/frame markers and sticky sprite-0-hit/underflow flags.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                frame_start                - begin (or restart) a frame
//                grp_valid/grp_ready        - group handshake
//                grp_pixels/grp_sprite0_hit - group payload (slot 7 leftmost)
//                pix_en                     - dot enable
//                pix_valid/pix_data/pix_x/pix_y/line_end/frame_end
//                                           - registered pixel output
//                sprite0_hit_flag, underflow_flag - sticky status
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_line_serializer
   import ppu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int H_PIXELS   = PPU_H_PIXELS,
   parameter int V_LINES    = PPU_V_LINES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        grp_valid,
   output logic        grp_ready,
   input  logic [63:0] grp_pixels,
   input  logic        grp_sprite0_hit,
   input  logic        pix_en,
   output logic        pix_valid,
   output logic [7:0]  pix_data,
   output logic [7:0]  pix_x,
   output logic [7:0]  pix_y,
   output logic        line_end,
   output logic        frame_end,
   output logic        sprite0_hit_flag,
   output logic        underflow_flag
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0] C_LAST_X = 8'(H_PIXELS - 1);
   localparam logic [7:0] C_LAST_Y = 8'(V_LINES - 1);

   ser_state_e state_q, state_d;

   logic [GROUP_W-1:0] w_head;
   logic [CW-1:0]      w_fifo_count;
   logic               w_fifo_full;
   logic               w_fifo_empty;

   logic w_active, w_emit, w_boundary, w_push, w_pop, w_last_x, w_last_y;

   // Remaining pixels of the current span, left-aligned so [63:56] is next
   logic [63:0] shift_q, shift_d;
   logic [2:0]  slot_q,  slot_d;
   logic [7:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;

   logic       pix_valid_q, pix_valid_d;
   logic [7:0] pix_data_q,  pix_data_d;
   logic [7:0] pix_x_q,     pix_x_d;
   logic [7:0] pix_y_q,     pix_y_d;
   logic       line_end_q,  line_end_d;
   logic       frame_end_q, frame_end_d;
   logic       s0_flag_q,   s0_flag_d;
   logic       uf_flag_q,   uf_flag_d;

   assign w_active   = (state_q == ST_ACTIVE);
   assign w_emit     = w_active && pix_en && !frame_start;
   assign w_boundary = (slot_q == 3'd0);
   assign w_last_x   = (x_q == C_LAST_X);
   assign w_last_y   = (y_q == C_LAST_Y);

   // Ready uses the registered full flag, so a push never meets a pop at full
   assign grp_ready = w_active && !w_fifo_full && !frame_start;
   assign w_push    = grp_valid && grp_ready;
   assign w_pop     = w_emit && w_boundary && !w_fifo_empty;

   pixel_group_fifo #(
      .WIDTH (GROUP_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (frame_start),
      .push_i    (w_push),
      .wr_data_i ({grp_sprite0_hit, grp_pixels}),
      .pop_i     (w_pop),
      .rd_data_o (w_head),
      .count_o   (w_fifo_count),
      .full_o    (w_fifo_full),
      .empty_o   (w_fifo_empty)
   );

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         state_d = ST_ACTIVE;
      end else if (w_emit && w_last_x && w_last_y) begin
         state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ------------------------------------------------- shifter and raster
   always_comb begin
      shift_d     = shift_q;
      slot_d      = slot_q;
      x_d         = x_q;
      y_d         = y_q;
      pix_valid_d = 1'b0;
      pix_data_d  = pix_data_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      line_end_d  = 1'b0;
      frame_end_d = 1'b0;
      s0_flag_d   = s0_flag_q;
      uf_flag_d   = uf_flag_q;

      if (frame_start) begin
         shift_d   = '0;
         slot_d    = '0;
         x_d       = '0;
         y_d       = '0;
         s0_flag_d = 1'b0;
         uf_flag_d = 1'b0;
      end else if (w_emit) begin
         pix_valid_d = 1'b1;
         pix_x_d     = x_q;
         pix_y_d     = y_q;
         line_end_d  = w_last_x;
         frame_end_d = w_last_x && w_last_y;

         if (w_boundary) begin
            slot_d = 3'd7;
            if (w_fifo_empty) begin
               // Starved span: the whole span shows backdrop, nothing is lost
               pix_data_d = BACKDROP_IDX;
               shift_d    = {8{BACKDROP_IDX}};
               uf_flag_d  = 1'b1;
            end else begin
               pix_data_d = w_head[63:56];
               shift_d    = {w_head[55:0], 8'h00};
               if (w_head[64]) s0_flag_d = 1'b1;
            end
         end else begin
            slot_d     = slot_q - 3'd1;
            pix_data_d = shift_q[63:56];
            shift_d    = {shift_q[55:0], 8'h00};
         end

         if (w_last_x) begin
            x_d = '0;
            y_d = w_last_y ? 8'd0 : y_q + 8'd1;
         end else begin
            x_d = x_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q     <= '0;
         slot_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         line_end_q  <= 1'b0;
         frame_end_q <= 1'b0;
         s0_flag_q   <= 1'b0;
         uf_flag_q   <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         slot_q      <= slot_d;
         x_q         <= x_d;
         y_q         <= y_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         line_end_q  <= line_end_d;
         frame_end_q <= frame_end_d;
         s0_flag_q   <= s0_flag_d;
         uf_flag_q   <= uf_flag_d;
      end
   end

   assign pix_valid        = pix_valid_q;
   assign pix_data         = pix_data_q;
   assign pix_x            = pix_x_q;
   assign pix_y            = pix_y_q;
   assign line_end         = line_end_q;
   assign frame_end        = frame_end_q;
   assign sprite0_hit_flag = s0_flag_q;
   assign underflow_flag   = uf_flag_q;

endmodule : pixel_line_serializer
`default_nettype wire

// File: tb/tb_pixel_line_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pixel_line_serializer
//  Description : Scoreboard bench for pixel_line_serializer. A queue-based
//                raster model produces expected pixels; a monitor compares
//                them whenever the design presents pix_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_line_serializer;

   localparam int DEPTH = 4;
   localparam int HP    = 256;
   localparam int VL    = 240;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        grp_valid = 1'b0;
   logic        grp_ready;
   logic [63:0] grp_pixels = '0;
   logic        grp_sprite0_hit = 1'b0;
   logic        pix_en = 1'b0;
   logic        pix_valid;
   logic [7:0]  pix_data, pix_x, pix_y;
   logic        line_end, frame_end, sprite0_hit_flag, underflow_flag;

   pixel_line_serializer #(
      .FIFO_DEPTH (DEPTH),
      .H_PIXELS   (HP),
      .V_LINES    (VL)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .frame_start      (frame_start),
      .grp_valid        (grp_valid),
      .grp_ready        (grp_ready),
      .grp_pixels       (grp_pixels),
      .grp_sprite0_hit  (grp_sprite0_hit),
      .pix_en           (pix_en),
      .pix_valid        (pix_valid),
      .pix_data         (pix_data),
      .pix_x            (pix_x),
      .pix_y            (pix_y),
      .line_end         (line_end),
      .frame_end        (frame_end),
      .sprite0_hit_flag (sprite0_hit_flag),
      .underflow_flag   (underflow_flag)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] x;
      logic [7:0] y;
      logic       le;
      logic       fe;
   } pix_t;

   pix_t        sb[$];
   logic [64:0] m_gq[$];     // accepted groups not yet shown
   logic [7:0]  m_span[$];   // pixels left in the span on screen
   bit          m_active = 1'b0;
   int          m_p = 0;     // linear pixel index within the frame
   bit          m_s0 = 1'b0;
   bit          m_uf = 1'b0;
   int          frame_ends_seen = 0;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: every presented pixel must match the oldest expected one
   always @(negedge clk) begin
      if (rst_n && pix_valid) begin
         if (sb.size() == 0) begin
            chk("pix_valid_unexpected", {63'd0, pix_valid}, 64'd0);
         end else begin
            pix_t e;
            e = sb.pop_front();
            chk("pix_data",  {56'd0, pix_data}, {56'd0, e.d});
            chk("pix_x",     {56'd0, pix_x},    {56'd0, e.x});
            chk("pix_y",     {56'd0, pix_y},    {56'd0, e.y});
            chk("line_end",  {63'd0, line_end}, {63'd0, e.le});
            chk("frame_end", {63'd0, frame_end},{63'd0, e.fe});
            if (e.fe) frame_ends_seen++;
         end
      end
   end

   // One clock of stimulus; the model advances as the design will at the edge
   task automatic cycle(input bit fs, input bit gv, input bit pe,
                        input logic [63:0] px, input bit hit);
      bit          exp_ready;
      logic [64:0] g;
      pix_t        e;
      @(negedge clk);
      frame_start     = fs;
      grp_valid       = gv;
      pix_en          = pe;
      grp_pixels      = px;
      grp_sprite0_hit = hit;
      #1;
      exp_ready = m_active && (m_gq.size() < DEPTH) && !fs;
      chk("grp_ready", {63'd0, grp_ready}, {63'd0, exp_ready});
      chk("sprite0_hit_flag", {63'd0, sprite0_hit_flag}, {63'd0, m_s0});
      chk("underflow_flag", {63'd0, underflow_flag}, {63'd0, m_uf});
      chk("missing_pixel", 64'(sb.size()), 64'd0);
      if (fs) begin
         m_gq.delete();
         m_span.delete();
         m_p      = 0;
         m_s0     = 1'b0;
         m_uf     = 1'b0;
         m_active = 1'b1;
      end else begin
         if (pe && m_active) begin
            if (m_span.size() == 0) begin
               if (m_gq.size() > 0) begin
                  g = m_gq.pop_front();
                  if (g[64]) m_s0 = 1'b1;
                  for (int i = 7; i >= 0; i--) m_span.push_back(g[8*i +: 8]);
               end else begin
                  m_uf = 1'b1;
                  repeat (8) m_span.push_back(8'h00);
               end
            end
            e.d  = m_span.pop_front();
            e.x  = 8'(m_p % HP);
            e.y  = 8'(m_p / HP);
            e.le = (m_p % HP) == HP - 1;
            e.fe = e.le && ((m_p / HP) == VL - 1);
            sb.push_back(e);
            m_p++;
            if (e.fe) m_active = 1'b0;
         end
         if (gv && exp_ready) m_gq.push_back({hit, px});
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_pix_valid", {63'd0, pix_valid}, 64'd0);
      chk("rst_pix_data",  {56'd0, pix_data},  64'd0);
      chk("rst_pix_x",     {56'd0, pix_x},     64'd0);
      chk("rst_pix_y",     {56'd0, pix_y},     64'd0);
      chk("rst_line_end",  {63'd0, line_end},  64'd0);
      chk("rst_frame_end", {63'd0, frame_end}, 64'd0);
      chk("rst_s0_flag",   {63'd0, sprite0_hit_flag}, 64'd0);
      chk("rst_uf_flag",   {63'd0, underflow_flag},   64'd0);
      chk("rst_grp_ready", {63'd0, grp_ready}, 64'd0);
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic async_reset();
      @(negedge clk);
      #2;
      frame_start = 1'b0;
      grp_valid   = 1'b0;
      pix_en      = 1'b0;
      rst_n       = 1'b0;
      #1;
      check_reset_outputs();
      m_gq.delete();
      m_span.delete();
      sb.delete();
      m_active = 1'b0;
      m_p      = 0;
      m_s0     = 1'b0;
      m_uf     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      int fe_before;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;

      // Directed group 0x0706050403020100
      cycle(1, 0, 0, '0, 0);
      cycle(0, 1, 0, 64'h0706050403020100, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, '0, 0);
      cycle(0, 0, 0, '0, 0);

      // One hit group, then hit-free groups over slightly more than a line
      cycle(1, 0, 0, '0, 0);
      cycle(0, 1, 0, rnd64(), 1);
      for (int i = 0; i < 264; i++) cycle(0, 1, 1, rnd64(), 0);
      cycle(0, 0, 0, '0, 0);

      // Underflow span followed by real data
      cycle(1, 0, 0, '0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, '0, 0);
      cycle(0, 1, 0, 64'h8877665544332211, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, '0, 0);
      cycle(0, 0, 0, '0, 0);

      // Backpressure: fill the FIFO, then drain one span
      cycle(1, 0, 0, '0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, rnd64(), 0);
      cycle(0, 1, 1, rnd64(), 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, rnd64(), 0);
      for (int i = 0; i < 40; i++) cycle(0, 0, 1, '0, 0);

      // Randomized traffic with occasional restarts
      cycle(1, 0, 0, '0, 0);
      for (int i = 0; i < 3000; i++)
         cycle(($urandom_range(0, 499) == 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) != 0, rnd64(), $urandom_range(0, 7) == 0);

      // frame_start together with a valid group mid-line
      cycle(1, 1, 1, rnd64(), 1);
      for (int i = 0; i < 30; i++) cycle(0, 1, 1, rnd64(), $urandom_range(0, 3) == 0);

      // Asynchronous reset in the middle of a span
      cycle(0, 1, 1, rnd64(), 0);
      cycle(0, 0, 1, '0, 0);
      async_reset();
      cycle(0, 1, 1, rnd64(), 0);
      cycle(0, 0, 0, '0, 0);

      // Full frame at full rate, then pix_en keeps running past the frame
      fe_before = frame_ends_seen;
      cycle(1, 0, 0, '0, 0);
      cycle(0, 1, 0, rnd64(), 0);
      for (int i = 0; i < HP * VL + 20; i++) cycle(0, 1, 1, rnd64(), 0);
      cycle(0, 0, 0, '0, 0);
      chk("frame_end_count", 64'(frame_ends_seen - fe_before), 64'd1);

      cycle(0, 0, 0, '0, 0);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pixel_line_serializer
`default_nettype wire
